// File: rtl/mem_stage_if.sv
// Request/ready data-memory port between the memory pipeline stage and data memory.
// Word-addressed, 32-bit data, variable wait states signalled by mem_ready.
interface mem_stage_if #(
  parameter int unsigned AW = 6
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory loads/stores over a request/ready port,
// freezes upstream while an access is outstanding, and owns the MEM/WB register.
module mem_stage #(
  parameter int unsigned DATA_BASE = 1024,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned AW        = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic [3:0]         wb_reg_dest_in,
  input  logic [31:0]        alu_result_in,
  input  logic [31:0]        val_rm_in,
  mem_stage_if.master        mem,
  output logic               stall,
  output logic               wb_en_out,
  output logic               mem_r_en_out,
  output logic [3:0]         wb_reg_dest_out,
  output logic [31:0]        alu_result_out,
  output logic [31:0]        mem_data_out,
  output logic               addr_err
);

  localparam logic [31:0] BASE  = 32'(DATA_BASE);
  localparam logic [31:0] LIMIT = 32'(DATA_BASE + 4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic          acc, rd_only, in_range;
  logic [31:0]   offset;
  logic [AW-1:0] word_addr;
  logic [31:0]   rdata_q;
  logic          issue, capture, bubble, use_cap, err_set;

  // A simultaneous read+write request is treated as a store.
  assign acc       = mem_r_en_in | mem_w_en_in;
  assign rd_only   = mem_r_en_in & ~mem_w_en_in;
  assign in_range  = (alu_result_in >= BASE) && (alu_result_in < LIMIT);
  assign offset    = alu_result_in - BASE;
  assign word_addr = AW'(offset >> 2);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle control; stall depends only on state, acc, range.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    bubble  = 1'b0;
    use_cap = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc && in_range) begin
          stall   = 1'b1;
          issue   = 1'b1;
          bubble  = 1'b1;
          state_d = WAIT;
        end else if (acc) begin
          err_set = 1'b1;
        end
      end
      WAIT: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (mem.mem_ready) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        use_cap = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port, captured read data, sticky error flag and MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem.mem_req     <= 1'b0;
      mem.mem_we      <= 1'b0;
      mem.mem_addr    <= '0;
      mem.mem_wdata   <= '0;
      rdata_q         <= '0;
      addr_err        <= 1'b0;
      wb_en_out       <= 1'b0;
      mem_r_en_out    <= 1'b0;
      wb_reg_dest_out <= '0;
      alu_result_out  <= '0;
      mem_data_out    <= '0;
    end else begin
      if (issue) begin
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= mem_w_en_in;
        mem.mem_addr  <= word_addr;
        mem.mem_wdata <= val_rm_in;
      end else if (capture) begin
        mem.mem_req   <= 1'b0;
      end
      if (capture) rdata_q <= mem.mem_rdata;
      if (err_set) addr_err <= 1'b1;
      if (bubble) begin
        wb_en_out    <= 1'b0;
        mem_r_en_out <= 1'b0;
      end else begin
        wb_en_out       <= wb_en_in;
        mem_r_en_out    <= rd_only;
        wb_reg_dest_out <= wb_reg_dest_in;
        alu_result_out  <= alu_result_in;
        mem_data_out    <= (use_cap && rd_only) ? rdata_q : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized instructions,
// checked against an address-range/latency model and a reference memory image.
module tb_mem_stage;

  localparam int unsigned BASE  = 1024;
  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
  logic [3:0]  wb_reg_dest_in = '0;
  logic [31:0] alu_result_in = '0, val_rm_in = '0;
  logic        stall, wb_en_out, mem_r_en_out, addr_err;
  logic [3:0]  wb_reg_dest_out;
  logic [31:0] alu_result_out, mem_data_out;

  mem_stage_if #(.AW(6)) mif ();

  mem_stage #(.DATA_BASE(BASE), .DEPTH(DEPTH), .AW(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_en_in        (wb_en_in),
    .mem_r_en_in     (mem_r_en_in),
    .mem_w_en_in     (mem_w_en_in),
    .wb_reg_dest_in  (wb_reg_dest_in),
    .alu_result_in   (alu_result_in),
    .val_rm_in       (val_rm_in),
    .mem             (mif.master),
    .stall           (stall),
    .wb_en_out       (wb_en_out),
    .mem_r_en_out    (mem_r_en_out),
    .wb_reg_dest_out (wb_reg_dest_out),
    .alu_result_out  (alu_result_out),
    .mem_data_out    (mem_data_out),
    .addr_err        (addr_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] dev_mem [DEPTH];
  bit          ref_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},   32'(mif.mem_req), 32'h0);
    check({tag, "_mem_we"},    32'(mif.mem_we), 32'h0);
    check({tag, "_mem_addr"},  32'(mif.mem_addr), 32'h0);
    check({tag, "_mem_wdata"}, mif.mem_wdata, 32'h0);
    check({tag, "_stall"},     32'(stall), 32'h0);
    check({tag, "_wb_en"},     32'(wb_en_out), 32'h0);
    check({tag, "_r_en"},      32'(mem_r_en_out), 32'h0);
    check({tag, "_dest"},      32'(wb_reg_dest_out), 32'h0);
    check({tag, "_alu"},       alu_result_out, 32'h0);
    check({tag, "_data"},      mem_data_out, 32'h0);
    check({tag, "_addr_err"},  32'(addr_err), 32'h0);
  endtask

  // Drives one instruction (entered just after a rising edge), plays the memory
  // with a k-th-WAIT-cycle response, and compares against the model once MEM/WB loads.
  task automatic run_op(input bit wb, input bit r, input bit w, input logic [3:0] dest,
                        input logic [31:0] alu, input logic [31:0] rm, input int k);
    bit          acc, inr, done;
    int          word, stalls, reqs, cyc, exp_stall;
    logic [31:0] exp_data;
    acc  = r | w;
    inr  = (longint'(alu) >= longint'(BASE)) && (longint'(alu) < longint'(BASE + 4 * DEPTH));
    word = inr ? int'((alu - BASE) / 4) : 0;
    exp_stall = (acc && inr) ? 1 + k : 0;
    exp_data  = (acc && inr && r && !w) ? ref_mem[word] : 32'h0;
    if (acc && inr && w) ref_mem[word] = rm;
    if (acc && !inr) ref_err = 1'b1;

    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    wb_reg_dest_in = dest; alu_result_in = alu; val_rm_in = rm;
    done = 1'b0; stalls = 0; reqs = 0; cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (mif.mem_req) begin
        reqs++;
        check("req_addr", 32'(mif.mem_addr), 32'(word));
        check("req_we", 32'(mif.mem_we), 32'(w));
        if (w) check("req_wdata", mif.mem_wdata, rm);
        mif.mem_ready = (reqs == k);
        if (reqs == k) begin
          mif.mem_rdata = dev_mem[mif.mem_addr];
          if (mif.mem_we) dev_mem[mif.mem_addr] = mif.mem_wdata;
        end
      end else begin
        mif.mem_ready = 1'($urandom_range(0, 1));
        mif.mem_rdata = $urandom;
      end
      if (cyc > 0) check("bubble_wb_en", 32'(wb_en_out), 32'h0);
      if (stall) stalls++;
      else done = 1'b1;
      cyc++;
      @(posedge clk); #1;
    end
    mif.mem_ready = 1'b0;
    check("op_completed", 32'(done), 32'h1);
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    check("req_cycles", 32'(reqs), (acc && inr) ? 32'(k) : 32'h0);
    check("wb_en_out", 32'(wb_en_out), 32'(wb));
    check("mem_r_en_out", 32'(mem_r_en_out), 32'(r && !w));
    check("wb_reg_dest_out", 32'(wb_reg_dest_out), 32'(dest));
    check("alu_result_out", alu_result_out, alu);
    check("mem_data_out", mem_data_out, exp_data);
    check("addr_err", 32'(addr_err), 32'(ref_err));
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = $urandom;
      dev_mem[i] = ref_mem[i];
    end
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Plain ALU op and the spec store/load scenarios
    run_op(1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'h0, 1);
    run_op(1'b0, 1'b0, 1'b1, 4'd0, 32'd1032, 32'hDEADBEEF, 1);
    ref_mem[2] = 32'h12345678;
    dev_mem[2] = 32'h12345678;
    run_op(1'b1, 1'b1, 1'b0, 4'd6, 32'd1032, 32'h0, 3);
    run_op(1'b1, 1'b1, 1'b0, 4'd1, 32'd1024, 32'h0, 1);
    run_op(1'b1, 1'b1, 1'b0, 4'd2, 32'd1028, 32'h0, 1);

    // Read+write together behaves as a store; then read it back (offset bits ignored)
    run_op(1'b1, 1'b1, 1'b1, 4'd5, 32'd1040, 32'hCAFEF00D, 2);
    run_op(1'b1, 1'b1, 1'b0, 4'd5, 32'd1043, 32'h0, 2);

    // Reset while WAITing, then a stray mem_ready pulse
    wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b0;
    wb_reg_dest_in = 4'd9; alu_result_in = 32'd1048; val_rm_in = 32'h0;
    @(negedge clk);
    check("pre_rst_stall", 32'(stall), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", 32'(mif.mem_req), 32'h1);
    rst = 1'b1;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; wb_reg_dest_in = '0; alu_result_in = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_err = 1'b0;
    check_all_zero("rst_in_wait");
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mif.mem_ready = 1'b0;
    check("stray_ready_req", 32'(mif.mem_req), 32'h0);
    check("stray_ready_stall", 32'(stall), 32'h0);
    run_op(1'b1, 1'b1, 1'b0, 4'd4, 32'd1048, 32'h0, 2);

    // Out-of-range load sets the sticky error; it survives a valid access
    run_op(1'b1, 1'b1, 1'b0, 4'd7, 32'd900, 32'h0, 1);
    run_op(1'b1, 1'b1, 1'b0, 4'd8, 32'd1036, 32'h0, 1);

    // Range boundaries
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; ref_err = 1'b0;
    run_op(1'b0, 1'b0, 1'b1, 4'd0, 32'd1279, 32'h0BADF00D, 1);
    run_op(1'b1, 1'b1, 1'b0, 4'd10, 32'd1276, 32'h0, 1);
    run_op(1'b0, 1'b0, 1'b1, 4'd0, 32'd1280, 32'h11111111, 1);
    run_op(1'b1, 1'b1, 1'b0, 4'd11, 32'd1023, 32'h0, 1);
    run_op(1'b1, 1'b1, 1'b0, 4'd12, 32'hFFFF_FFF0, 32'h0, 1);

    // Randomized instruction stream
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; ref_err = 1'b0;
    for (int i = 0; i < 80; i++) begin
      int          sel;
      logic [31:0] alu;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       alu = 32'(BASE + $urandom_range(0, 4 * DEPTH - 1));
      else if (sel == 7) alu = 32'($urandom_range(0, BASE - 1));
      else if (sel == 8) alu = 32'(BASE + 4 * DEPTH + $urandom_range(0, 1000));
      else               alu = $urandom;
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), alu, $urandom, int'($urandom_range(1, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage: consumes ALU result, Rm value and control bits, and performs data-memory loads/stores through a request/ready memory port with variable wait states.
- Owns the MEM/WB pipeline register.
- Raises a freeze (stall) signal to all upstream stages while an access is outstanding.

Parameters:
- DATA_BASE, 1024: byte address mapped to word 0 of data memory.
- DEPTH, 64: number of 32-bit words in data memory.
- AW, 6: memory word-address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- wb_en_in  in  1  write-back enable from execute.
- mem_r_en_in  in  1  load request.
- mem_w_en_in  in  1  store request.
- wb_reg_dest_in  in  4  destination register.
- alu_result_in  in  32  byte address (memory ops) or result (others).
- val_rm_in  in  32  store data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  AW  word address, registered.
- mem_wdata  out  32  write data, registered.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- mem_ready  in  1  access complete this cycle.
- stall  out  1  freeze upstream PC and pipeline registers; combinational.
- wb_en_out  out  1  MEM/WB register.
- mem_r_en_out  out  1  MEM/WB register; selects load data in write-back.
- wb_reg_dest_out  out  4  MEM/WB register.
- alu_result_out  out  32  MEM/WB register.
- mem_data_out  out  32  MEM/WB register; load data.
- addr_err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (synchronous): FSM goes to IDLE. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, all MEM/WB fields, addr_err. Any pending access is abandoned.
- acc = mem_r_en_in | mem_w_en_in. If both r and w are set, the access is a write and mem_r_en_out=0.
- Word address = (alu_result_in - DATA_BASE) >> 2, truncated to AW bits. Byte-offset bits [1:0] are ignored.
- In range: DATA_BASE <= alu_result_in < DATA_BASE + 4*DEPTH. Compare using unsigned 32-bit arithmetic.
- FSM states: IDLE, WAIT, DONE.
- IDLE, acc=0: stall=0. MEM/WB loads the inputs each cycle (1-cycle latency) with mem_data_out=0.
- IDLE, acc=1, out of range:
  - No request is issued and stall=0.
  - addr_err set to 1 (stays set until reset).
  - MEM/WB loads the inputs with mem_data_out=0; a store is dropped.
- IDLE, acc=1, in range:
  - stall=1.
  - Latch mem_addr, mem_we=mem_w_en_in, mem_wdata=val_rm_in; set mem_req=1.
  - Go to WAIT. MEM/WB loads a bubble: wb_en_out=0, mem_r_en_out=0, other fields hold.
- WAIT:
  - stall=1; mem_req, mem_we, mem_addr, mem_wdata held stable.
  - MEM/WB loads a bubble each cycle.
  - On mem_ready=1: capture mem_rdata into an internal register (captured for writes too; unused), clear mem_req, go to DONE.
  - mem_ready is sampled only in WAIT and ignored in IDLE/DONE. No timeout.
- DONE:
  - stall=0; inputs still present the same instruction.
  - MEM/WB loads the inputs, plus the captured data into mem_data_out when mem_r_en_in=1 (0 for stores).
  - Unconditional return to IDLE, so the same instruction is never re-issued.
- Timing, in-range access with mem_ready on the first WAIT cycle:
  - stall high for exactly 2 cycles (IDLE-detect and WAIT).
  - MEM/WB updated at the end of the 3rd cycle.
  - Each extra wait cycle adds one stall cycle.
- Back-to-back memory ops: after DONE the next instruction is evaluated in IDLE on the following cycle.
- stall is a function of state, acc, range and mem_ready only. It has no path from mem_rdata.

Test Plan:
- Reset, then ALU op (wb_en=1, dest=3, alu_result=0x55) -> next cycle wb_en_out=1, wb_reg_dest_out=3, alu_result_out=0x55, stall never 1.
- Store val_rm=0xDEADBEEF to 1032, mem_ready asserted on first WAIT cycle:
  - mem_req=1, mem_we=1, mem_addr=2, mem_wdata=0xDEADBEEF for one cycle.
  - stall high 2 cycles; wb_en_out=0 during those cycles.
- Load from 1032, mem_ready delayed 3 WAIT cycles with mem_rdata=0x12345678:
  - stall high 4 cycles; mem_addr stable throughout.
  - After DONE: mem_r_en_out=1, mem_data_out=0x12345678.
- Load from 900 (below DATA_BASE) -> no mem_req, stall=0, addr_err=1 and stays 1 through a following valid access; mem_data_out=0.
- rst asserted during WAIT (mem_ready=0) -> next cycle mem_req=0, stall=0, state IDLE, all outputs 0; a later mem_ready pulse is ignored.
- Two consecutive loads (1024 then 1028, mem_ready immediate) -> two separate requests with mem_addr 0 then 1, 4 stall cycles total, each result written to MEM/WB exactly once.
